// File: rtl/seq_addsub.sv
// Sequential adder/subtractor: a WIDTH-bit operand pair is consumed DIGIT bits
// per clock through a registered carry, framed by a start/busy/done handshake.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_addsub: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  res;
  logic              carry;

  logic              accept;
  logic              last;
  logic [DIGIT-1:0]  dig_a;
  logic [DIGIT-1:0]  dig_b;
  logic [DIGIT:0]    dig_tot;
  logic [DIGIT-1:0]  dig_sum;
  logic              dig_co;
  logic              msb_ci;
  logic [WIDTH-1:0]  res_nx;

  // Handshake: start is taken only while busy=0 (IDLE or DONE); once taken,
  // busy stays high for N cycles, then done pulses for one cycle with the
  // new sum/cout/ovf. A start seen during that DONE cycle is accepted too.
  always_comb begin
    state_nx = state;
    accept   = start && (state != ST_RUN);
    last     = (cnt == CW'(N - 1));
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operands shift right so the active digit is always at bit 0; result
  // digits enter at the top and have walked down to their slot after N shifts.
  always_comb begin
    dig_a   = op_a[DIGIT-1:0];
    dig_b   = op_b[DIGIT-1:0];
    dig_tot = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry};
    dig_sum = dig_tot[DIGIT-1:0];
    dig_co  = dig_tot[DIGIT];
    msb_ci  = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_sum[DIGIT-1];
    res_nx  = (res >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_RUN);
      done  <= (state_nx == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == ST_RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      res   <= res_nx;
      carry <= dig_co;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        sum  <= res_nx;
        cout <= dig_co;
        ovf  <= msb_ci ^ dig_co;
      end
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: four parameterisations side by side, an arithmetic
// reference model checked every cycle, plus directed literal checks.
module tb_seq_addsub;

  localparam int NI = 4;
  localparam int WV [NI] = '{16, 16, 8, 12};
  localparam int NV [NI] = '{4, 16, 1, 4};

  logic        clk;
  logic        rst;
  logic        start_v [NI];
  logic        sub_v   [NI];
  logic        cin_v   [NI];
  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        cout_v  [NI];
  logic        ovf_v   [NI];
  logic [15:0] sum_v   [NI];
  logic [7:0]  sum_8;
  logic [11:0] sum_12;

  int tests = 0;
  int fails = 0;

  assign sum_v[2] = {8'h00, sum_8};
  assign sum_v[3] = {4'h0, sum_12};

  seq_addsub #(.WIDTH(16), .DIGIT(4)) u_w16_d4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  seq_addsub #(.WIDTH(16), .DIGIT(1)) u_w16_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  seq_addsub #(.WIDTH(8), .DIGIT(8)) u_w8_d8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_8), .cout(cout_v[2]), .ovf(ovf_v[2]));
  seq_addsub #(.WIDTH(12), .DIGIT(3)) u_w12_d3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_v[3]), .a(a_v[3][11:0]), .b(b_v[3][11:0]),
    .cin(cin_v[3]), .busy(busy_v[3]), .done(done_v[3]), .sum(sum_12), .cout(cout_v[3]), .ovf(ovf_v[3]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_left [NI];
  logic        m_done [NI];
  logic [15:0] m_sum  [NI];
  logic        m_cout [NI];
  logic        m_ovf  [NI];
  logic [17:0] m_pend [NI];

  // Returns {ovf, cout, sum[15:0]} for a w-bit add/subtract.
  function automatic logic [17:0] arith(int w, logic [15:0] a, logic [15:0] b, logic s, logic c);
    logic [16:0] mask;
    logic [16:0] aa;
    logic [16:0] bb;
    logic [16:0] tot;
    logic [16:0] r;
    logic        co;
    logic        ov;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    tot  = aa + bb + {16'd0, c ^ s};
    r    = tot & mask;
    co   = tot[w];
    ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {ov, co, r[15:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
        m_sum[i]  <= '0;
        m_cout[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
        m_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] <= 1'b0;
        if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_done[i] <= 1'b1;
            m_sum[i]  <= m_pend[i][15:0];
            m_cout[i] <= m_pend[i][16];
            m_ovf[i]  <= m_pend[i][17];
          end
        end else if (start_v[i]) begin
          m_pend[i] <= arith(WV[i], a_v[i], b_v[i], sub_v[i], cin_v[i]);
          m_left[i] <= NV[i];
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle, every instance ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        logic [19:0] act;
        logic [19:0] exp;
        act = {busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]};
        exp = {m_left[i] > 0, m_done[i], m_cout[i], m_ovf[i], m_sum[i]};
        tests++;
        if (act !== exp) begin
          fails++;
          $display("FAIL cycle_cmp[%0d] t=%0t: busy/done/cout/ovf/sum got %b/%b/%b/%b/%h, required %b/%b/%b/%b/%h",
                   i, $time, act[19], act[18], act[17], act[16], act[15:0],
                   exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c);
    @(negedge clk);
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; sub_v[i] = s; cin_v[i] = c;
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = 16'($urandom); b_v[i] = 16'($urandom);
    sub_v[i] = 1'($urandom_range(0, 1)); cin_v[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int i, input bit noise, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done_v[i] && lat < 200) begin
      if (busy_v[i]) busy_n++;
      if (noise) begin
        start_v[i] = 1'($urandom_range(0, 1));
        a_v[i] = 16'($urandom); b_v[i] = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start_v[i] = 1'b0;
    if (!done_v[i]) begin
      tests++;
      fails++;
      $display("FAIL wait_done[%0d]: no done after %0d cycles, required done=1", i, lat);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input int i, input logic [15:0] es,
                           input logic ec, input logic eo);
    tests++;
    if ({sum_v[i], cout_v[i], ovf_v[i]} !== {es, ec, eo}) begin
      fails++;
      $display("FAIL %s: dut sum/cout/ovf got %h/%b/%b, required %h/%b/%b",
               name, sum_v[i], cout_v[i], ovf_v[i], es, ec, eo);
    end
    tests++;
    if ({m_sum[i], m_cout[i], m_ovf[i]} !== {es, ec, eo}) begin
      fails++;
      $display("FAIL %s_model: model sum/cout/ovf got %h/%b/%b, required %h/%b/%b",
               name, m_sum[i], m_cout[i], m_ovf[i], es, ec, eo);
    end
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input logic [15:0] es,
                          input logic ec, input logic eo);
    int lat;
    int bn;
    start_op(0, a, b, s, c);
    wait_done(0, 1'b0, lat, bn);
    check_res(name, 0, es, ec, eo);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int bn;
    int gap;
    int dcount;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_res($sformatf("reset_out[%0d]", i), i, 16'h0000, 1'b0, 1'b0);
      check_int($sformatf("reset_busy_done[%0d]", i), {busy_v[i], done_v[i]}, 0);
    end

    // Basic add with latency and busy length.
    start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(0, 1'b0, lat, bn);
    check_res("add_5555", 0, 16'h5555, 1'b0, 1'b0);
    check_int("latency_w16_d4", lat, 4);
    check_int("busy_len_w16_d4", bn, 4);
    @(negedge clk);
    check_int("done_one_cycle", done_v[0], 0);

    directed("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    directed("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    directed("add_cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);

    // start held through RUN with changing operands, then accepted in DONE.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 16'h1111; b_v[0] = 16'h2222; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!done_v[0] && lat < 50) begin
      a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
      sub_v[0] = 1'($urandom_range(0, 1)); cin_v[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    check_res("start_held_first_ops", 0, 16'h3333, 1'b0, 1'b0);
    a_v[0] = 16'h0100; b_v[0] = 16'h0023; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
    gap = 0;
    do begin
      @(negedge clk);
      start_v[0] = 1'b0;
      gap++;
    end while (!done_v[0] && gap < 50);
    check_int("back_to_back_gap", gap, 5);
    check_res("back_to_back_second", 0, 16'h0123, 1'b0, 1'b0);

    // Reset while the digit counter is at 2.
    start_op(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_res("async_reset_out", 0, 16'h0000, 1'b0, 1'b0);
    check_int("async_reset_busy_done", {busy_v[0], done_v[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    check_int("no_done_after_reset", dcount, 0);
    directed("after_reset", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Latency of the other parameterisations.
    for (int i = 1; i < NI; i++) begin
      start_op(i, 16'h0003, 16'h0005, 1'b0, 1'b0);
      wait_done(i, 1'b0, lat, bn);
      check_int($sformatf("latency[%0d]", i), lat, NV[i]);
      check_int($sformatf("busy_len[%0d]", i), bn, NV[i]);
      check_res($sformatf("add_3_5[%0d]", i), i, 16'h0008, 1'b0, 1'b0);
    end

    // Random sweeps; the scoreboard checks every cycle.
    for (int i = 0; i < NI; i++) begin
      int nvec;
      nvec = (i == 0) ? 50 : 200;
      for (int k = 0; k < nvec; k++) begin
        start_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        wait_done(i, bit'($urandom_range(0, 1)), lat, bn);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
